// File: rtl/sha256_pkg.sv
// Shared types, constants and round functions for the SHA-256 compression controller.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Working variables packed a..h from MSB to LSB, matching the digest word order.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV_FLAT = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: a..h plus K and W in, next a..h out.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t i_work,
    input  word_t i_k,
    input  word_t i_w,
    output work_t o_work
);

    word_t w_t1;
    word_t w_t2;

    // Round adders and working-variable rotation.
    always_comb begin
        w_t1       = i_work.h + big_sigma1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_k + i_w;
        w_t2       = big_sigma0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);
        o_work     = '0;
        o_work.a   = w_t1 + w_t2;
        o_work.b   = i_work.a;
        o_work.c   = i_work.b;
        o_work.d   = i_work.c;
        o_work.e   = i_work.d + w_t1;
        o_work.f   = i_work.e;
        o_work.g   = i_work.f;
        o_work.h   = i_work.g;
    end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 block sequencer: FSM, round counter, rolling schedule and chaining registers.
// Optional SHA256_BLOCK_CNT_EN adds a 32-bit completed-block counter output blk_cnt.
module sha256_compress_ctrl
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic                     blk_first,
    input  logic [16*DATA_WIDTH-1:0] blk_data,
    output logic                     dig_valid,
    input  logic                     dig_ready,
    output logic [8*DATA_WIDTH-1:0]  digest
`ifdef SHA256_BLOCK_CNT_EN
    ,
    output logic [31:0]              blk_cnt
`endif
);

    if (DATA_WIDTH != 32 || ROUNDS != 64) begin : g_param_err
        $error("sha256_compress_ctrl supports only DATA_WIDTH=32 and ROUNDS=64");
    end

    localparam int                CNT_W    = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ROUNDS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_blk_ready;
    logic             r_dig_valid;
    logic [CNT_W-1:0] r_cnt;
    work_t            r_work;
    work_t            w_work_nxt;
    word_t            r_w [0:15];
    word_t            r_h [0:7];
    word_t            w_w_new;
    logic [255:0]     w_h_flat;
    logic [255:0]     w_work_flat;
    logic             w_accept;

    assign w_accept    = blk_valid & r_blk_ready;
    assign w_h_flat    = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};
    assign w_work_flat = r_work;
    assign w_w_new     = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

    assign blk_ready = r_blk_ready;
    assign dig_valid = r_dig_valid;
    assign digest    = w_h_flat;

    sha256_round u_round (
        .i_work (r_work),
        .i_k    (K[r_cnt]),
        .i_w    (r_w[0]),
        .o_work (w_work_nxt)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = ROUND;
                else          w_state_nxt = IDLE;
            end
            ROUND: begin
                if (r_cnt == CNT_LAST) w_state_nxt = FINAL;
                else                   w_state_nxt = ROUND;
            end
            FINAL: w_state_nxt = DONE;
            DONE: begin
                if (dig_ready) w_state_nxt = IDLE;
                else           w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_blk_ready <= 1'b1;
            r_dig_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk_ready <= (w_state_nxt == IDLE);
            r_dig_valid <= (w_state_nxt == DONE);
        end
    end

    // Working variables, message schedule, round counter and chaining registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            for (int i = 0; i < 16; i++) r_w[i] <= 32'h0000_0000;
            for (int i = 0; i < 8; i++)  r_h[i] <= IV[i];
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < 16; i++) r_w[i] <= blk_data[511-32*i -: 32];
                        r_cnt <= '0;
                        if (blk_first) begin
                            r_work <= IV_FLAT;
                            for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
                        end else begin
                            r_work <= w_h_flat;
                        end
                    end
                end
                ROUND: begin
                    r_work <= w_work_nxt;
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                    r_w[15] <= w_w_new;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + w_work_flat[255-32*i -: 32];
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SHA256_BLOCK_CNT_EN
    logic [31:0] r_blk_cnt;

    // Completed-block counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_blk_cnt <= 32'h0000_0000;
        else if (r_state == FINAL)  r_blk_cnt <= r_blk_cnt + 32'h0000_0001;
        else                        r_blk_cnt <= r_blk_cnt;
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Scoreboard bench for sha256_compress_ctrl against a plain FIPS 180-4 reference model.
module tb_sha256_compress_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic [511:0] blk_data;
    logic         dig_valid;
    logic         dig_ready;
    logic [255:0] digest;
`ifdef SHA256_BLOCK_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    always #5 clk = ~clk;

    sha256_compress_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_data  (blk_data),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .digest    (digest)
`ifdef SHA256_BLOCK_CNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV_C = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] TWO_BLK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {448'h0, 32'h00000000, 32'h000001c0};
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    int           n_vec = 0;
    int           n_err = 0;
    int           blocks_done = 0;
    logic [255:0] exp_q [$];
    logic [255:0] model_h;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward FIPS 180-4 compression with a full 64-entry schedule.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  hh [8];
        logic [31:0]  s0, s1, t1, t2, chv, mjv;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            hh[i] = hin[255-32*i -: 32];
            v[i]  = hh[i];
        end
        for (int t = 0; t < 64; t++) begin
            s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1  = v[7] + s1 + chv + KT[t] + w[t];
            s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2  = s0 + mjv;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hh[i] + v[i];
        return res;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare each digest handshake against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && dig_valid === 1'b1 && dig_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL digest_unexpected: got %h with no expected digest queued", digest);
            end else begin
                check("digest", digest, exp_q.pop_front());
            end
        end
    end

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
        return b;
    endfunction

    task automatic accept_blk(input logic [511:0] data, input logic first, output bit ok);
        int n = 0;
        blk_valid = 1'b1;
        blk_data  = data;
        blk_first = first;
        while (blk_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (blk_ready === 1'b1);
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: blk_ready got %b required 1", blk_ready);
        end else begin
            @(posedge clk); #1;
        end
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_data  = rand_blk();
    endtask

    task automatic wait_digest(input bit chk_lat, output bit ok);
        int n = 0;
        while (dig_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (dig_valid === 1'b1);
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL digest_timeout: dig_valid got %b required 1", dig_valid);
        end else if (chk_lat) begin
            check("latency", 256'(n), 256'd65);
        end
    endtask

    task automatic release_dig(input int delay, input bit bp, input bit simul);
        for (int i = 0; i < delay; i++) begin
            blk_valid = bp ? ~blk_valid : 1'b0;
            @(posedge clk); #1;
            check("busy_blk_ready", 256'(blk_ready), 256'd0);
            check("held_dig_valid", 256'(dig_valid), 256'd1);
            check("held_digest", digest, exp_q[0]);
        end
        blk_valid = simul;
        dig_ready = 1'b1;
        @(posedge clk); #1;
        dig_ready = 1'b0;
        check("dig_valid_drop", 256'(dig_valid), 256'd0);
        check("blk_ready_back", 256'(blk_ready), 256'd1);
        blk_valid = 1'b0;
    endtask

    task automatic do_block(input logic [511:0] data, input logic first, input bit known,
                            input logic [255:0] kval, input bit chk_lat,
                            input int delay, input bit bp, input bit simul);
        logic [255:0] m;
        bit           ok;
        m       = ref_compress(first ? IV_C : model_h, data);
        model_h = m;
        exp_q.push_back(known ? kval : m);
        accept_blk(data, first, ok);
        if (ok) wait_digest(chk_lat, ok);
        if (ok) begin
            release_dig(delay, bp, simul);
            blocks_done++;
        end else begin
            void'(exp_q.pop_back());
        end
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_data  = '0;
        dig_ready = 1'b0;
        model_h   = IV_C;
        repeat (3) @(posedge clk);
        #1;
        check("rst_blk_ready", 256'(blk_ready), 256'd1);
        check("rst_dig_valid", 256'(dig_valid), 256'd0);
        check("rst_digest", digest, IV_C);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_blk_ready", 256'(blk_ready), 256'd1);

        do_block(ABC_BLK, 1'b1, 1'b1, ABC_DIG, 1'b1, 0, 1'b0, 1'b0);
        do_block(EMPTY_BLK, 1'b1, 1'b1, EMPTY_DIG, 1'b1, 3, 1'b0, 1'b0);
        do_block(TWO_BLK1, 1'b1, 1'b0, '0, 1'b0, 1, 1'b0, 1'b0);
        do_block(TWO_BLK2, 1'b0, 1'b1, TWO_DIG, 1'b1, 20, 1'b1, 1'b0);
        do_block(rand_blk(), 1'b1, 1'b0, '0, 1'b0, 2, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            do_block(rand_blk(), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0,
                     int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Abort a block at round 30; the reset must take effect without a clock edge.
        accept_blk(rand_blk(), 1'b1, ok);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_dig_valid", 256'(dig_valid), 256'd0);
        check("abort_digest", digest, IV_C);
        check("abort_blk_ready", 256'(blk_ready), 256'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_h     = IV_C;
        blocks_done = 0;
        do_block(ABC_BLK, 1'b0, 1'b1, ABC_DIG, 1'b1, 1, 1'b0, 1'b0);

`ifdef SHA256_BLOCK_CNT_EN
        do_block(rand_blk(), 1'b1, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        do_block(rand_blk(), 1'b0, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        check("blk_cnt_three", 256'(blk_cnt), 256'd3);
        force dut.r_blk_cnt = 32'hffff_ffff;
        #1;
        release dut.r_blk_cnt;
        do_block(rand_blk(), 1'b1, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        check("blk_cnt_wrap", 256'(blk_cnt), 256'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
